// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : counter_pkg                                                      |
// | Brief   : Shared direction constants and default-limit helper for the      |
// |           parameterised up/down counter.                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Largest value representable in 'width' bits (2**width - 1).
  function automatic int unsigned default_max(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udcnt_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : udcnt_next                                                       |
// | Brief   : Combinational next-count for one enabled step, with overflow and |
// |           underflow flags. Saturate/wrap selection exists only when the    |
// |           UDCNT_SAT_EN macro is defined; otherwise the step always wraps.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module udcnt_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = default_max(WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             updown,
`ifdef UDCNT_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_step,
  output logic             unf_step
);

  localparam logic [WIDTH-1:0] c_max  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic w_sat;

`ifdef UDCNT_SAT_EN
  assign w_sat = sat_mode;
`else
  // Wrap-only build: the constant folds away every saturate path.
  assign w_sat = 1'b0;
`endif

  // One enabled step: in-range moves by one, out-of-range wraps or holds and flags.
  always_comb begin
    next_count = count;
    ovf_step   = 1'b0;
    unf_step   = 1'b0;
    if (updown == CNT_UP) begin
      // '>=' keeps the result inside 0..MAX even if count were ever above the limit.
      if (count >= c_max) begin
        ovf_step   = 1'b1;
        next_count = w_sat ? c_max : c_zero;
      end else begin
        next_count = count + c_one;
      end
    end else begin
      if (count == c_zero) begin
        unf_step   = 1'b1;
        next_count = w_sat ? c_zero : c_max;
      end else begin
        next_count = count - c_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : param_updown_counter                                             |
// | Brief   : WIDTH-bit up/down counter with upper limit MAX_VAL, priority     |
// |           clr > load > en, registered ovf/unf pulses and combinational tc. |
// |           Define UDCNT_SAT_EN to add the sat_mode port (saturate vs wrap). |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = default_max(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
`ifdef UDCNT_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] c_max = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_next;
  logic             w_ovf;
  logic             w_unf;
  logic [WIDTH-1:0] w_load_val;

  udcnt_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (r_count),
    .updown     (updown),
`ifdef UDCNT_SAT_EN
    .sat_mode   (sat_mode),
`endif
    .next_count (w_next),
    .ovf_step   (w_ovf),
    .unf_step   (w_unf)
  );

  // Loaded values above the limit are clamped so the register never leaves 0..MAX.
  assign w_load_val = (data > c_max) ? c_max : data;

  // Count and flag registers; flags pulse only on the cycle after an out-of-range step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_count <= w_next;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

  assign data_out = r_count;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

  // Terminal count looks at the limit in the currently selected direction.
  assign tc = ((updown == CNT_UP)   && (r_count == c_max)) ||
              ((updown == CNT_DOWN) && (r_count == '0));

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_param_updown_counter                                          |
// | Brief   : Scoreboard bench for param_updown_counter (WIDTH=4, MAX_VAL=9).  |
// |           Honours UDCNT_SAT_EN when defined.                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_param_updown_counter;

  localparam int W   = 4;
  localparam int MAX = 9;
`ifdef UDCNT_SAT_EN
  localparam bit SAT_BUILT = 1'b1;
`else
  localparam bit SAT_BUILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, clr, load, en, updown, sat_mode;
  logic [W-1:0] data;
  logic [W-1:0] data_out;
  logic         tc, ovf, unf;

  typedef struct {
    int due;
    int cnt;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;   // reference model count

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .en       (en),
    .updown   (updown),
    .data     (data),
`ifdef UDCNT_SAT_EN
    .sat_mode (sat_mode),
`endif
    .data_out (data_out),
    .tc       (tc),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference step from the current inputs, using modular arithmetic on 0..MAX.
  task automatic model_push();
    exp_t e;
    bit   sat;
    sat   = SAT_BUILT && sat_mode;
    e.due = cyc + 1;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (clr) begin
      m_cnt = 0;
    end else if (load) begin
      m_cnt = (int'(data) > MAX) ? MAX : int'(data);
    end else if (en && updown) begin
      e.ovf = (m_cnt + 1 > MAX);
      if (e.ovf && sat) m_cnt = MAX;
      else              m_cnt = (m_cnt + 1) % (MAX + 1);
    end else if (en) begin
      e.unf = (m_cnt - 1 < 0);
      if (e.unf && sat) m_cnt = 0;
      else              m_cnt = (m_cnt - 1 + MAX + 1) % (MAX + 1);
    end
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic step(input bit c, input bit l, input bit e, input bit u,
                      input int d, input bit s);
    @(posedge clk);
    #1;
    clr      = c;
    load     = l;
    en       = e;
    updown   = u;
    data     = W'(d);
    sat_mode = s;
    model_push();
  endtask

  // Monitor: compares every due expectation one edge after its stimulus.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("data_out", int'(data_out), e.cnt);
      chk("ovf", int'(ovf), int'(e.ovf));
      chk("unf", int'(unf), int'(e.unf));
      chk("tc", int'(tc), int'(updown ? (e.cnt == MAX) : (e.cnt == 0)));
    end
  end

  // Asynchronous reset between edges, with inputs left counting up.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst data_out", int'(data_out), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst unf", int'(unf), 0);
    m_cnt = 0;
    #1;
    rst_n = 1'b1;
    clr = 1'b0; load = 1'b0; en = 1'b1; updown = 1'b1;
    model_push();   // first edge after release counts from 0
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    updown = 1'b0; data = '0; sat_mode = 1'b0;
    #2;
    chk("reset data_out", int'(data_out), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset unf", int'(unf), 0);
    chk("reset tc down", int'(tc), 1);
    #6;
    rst_n = 1'b1;

    // Load clamp, and clr beating load.
    step(0, 1, 0, 1, 12, 0);
    step(1, 1, 0, 1, 5, 0);
    // Wrap up: 8 -> 9 -> 0 (ovf) -> 1.
    step(0, 1, 0, 1, 8, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0);
    // Wrap down: 1 -> 0 -> 9 (unf) -> 8.
    step(0, 1, 0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    // Saturate at 9 for three attempts, then reverse.
    step(0, 1, 0, 1, 9, 1);
    repeat (3) step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    // Saturate at 0.
    step(0, 1, 0, 0, 0, 1);
    repeat (2) step(0, 0, 1, 0, 0, 1);
    // Disabled with updown toggling: value holds, no flags.
    step(0, 1, 0, 0, 6, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 0, 0);
    // Mid-count reset at 5, then first edge evaluates from 0.
    step(0, 1, 0, 1, 4, 0);
    step(0, 0, 1, 1, 0, 0);
    mid_reset();
    step(0, 0, 1, 1, 0, 0);

    // Randomised traffic, biased toward enabled counting.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 4, (r >= 4) && (r < 12), $urandom_range(0, 9) < 8,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15),
           $urandom_range(0, 1) == 1);
    end

    step(0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
